seq_alu: RTL and testbench

Parametrised, handshaked successor to the 8-bit combinational ALU. Sits between the register-file read stage and the writeback stage of the core. Registers every result together with its flags. Adds three things the combinational ALU lacks: add-with-carry using the stored carry flag, an iterative unsigned multiply producing a double-width result, and an illegal-op flag. Single-cycle ops complete in one cycle; MUL takes WIDTH+1 cycles under valid/ready flow control.

---
 rtl/seq_alu_pkg.sv | 39 +++
 rtl/seq_alu_if.sv | 28 ++
 rtl/seq_alu_mul_seq.sv | 47 ++++
 rtl/seq_alu.sv | 167 ++++++++++++++++
 tb/tb_seq_alu.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Shared op codes, flag bit positions and FSM state type for seq_alu.
// The original 3-bit op values survive as the low bits of the 4-bit codes.
package seq_alu_pkg;

    localparam logic [3:0] OP_SUM = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_LSL = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_ADC = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam int FLAG_CARRY    = 0;
    localparam int FLAG_NEGATIVE = 1;
    localparam int FLAG_OVERFLOW = 2;
    localparam int FLAG_ZERO     = 3;
    localparam int FLAG_PARITY   = 4;
    localparam int FLAG_ILLEGAL  = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_HOLD
    } state_t;

    function automatic logic [7:0] pack_flags(
        input logic ill,
        input logic par,
        input logic zero,
        input logic ovf,
        input logic neg,
        input logic carry
    );
        return {2'b00, ill, par, zero, ovf, neg, carry};
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle between the read stage, seq_alu and writeback.
// master drives operands and consumes results; slave is the ALU.
interface seq_alu_if #(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    logic [7:0]       flags;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, out, out_hi, flags
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, out, out_hi, flags
    );

endinterface

// File: rtl/seq_alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle.
// Exposes the next accumulator value so the final step can be registered directly.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     psum;

    // acc = {partial high, remaining multiplier bits}; shift right each step
    always_comb begin
        psum    = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            psum = psum + {1'b0, mcand};
        end
        product = {psum, acc[WIDTH-1:1]};
        done    = (count == CW'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            acc   <= '0;
            mcand <= '0;
        end else if (start) begin
            count <= CW'(WIDTH);
            acc   <= {{WIDTH{1'b0}}, b};
            mcand <= a;
        end else if (count != '0) begin
            count <= count - CW'(1);
            acc   <= product;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU between register read and writeback: registered result and
// flags, ADC from the held carry, and a multi-cycle unsigned multiply.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic        clk,
    input logic        rst,
    seq_alu_if.slave   bus
);

    state_t state, state_nx;

    logic               accept;
    logic               is_mul;
    logic               load_alu;
    logic               load_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH-1:0]   res;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   nb;
    logic [WIDTH:0]     shl;
    logic [WIDTH:0]     shr;
    logic               c;
    logic               v;
    logic               ill;
    logic               arith;
    logic [7:0]         alu_flags;
    logic [7:0]         mul_flags;
    logic [WIDTH-1:0]   mul_lo;
    logic [WIDTH-1:0]   mul_hi;

    logic [WIDTH-1:0]   out_q;
    logic [WIDTH-1:0]   hi_q;
    logic [7:0]         flags_q;

    assign is_mul  = (bus.op == OP_MUL);
    assign accept  = bus.in_valid & bus.in_ready;

    assign bus.in_ready  = (state == ST_IDLE) |
                           ((state == ST_HOLD) & bus.out_ready);
    assign bus.out_valid = (state == ST_HOLD);
    assign bus.out       = out_q;
    assign bus.out_hi    = hi_q;
    assign bus.flags     = flags_q;

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept & is_mul),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load_alu = 1'b0;
        load_mul = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = is_mul ? ST_BUSY : ST_HOLD;
                    load_alu = ~is_mul;
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_nx = ST_HOLD;
                    load_mul = 1'b1;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    state_nx = is_mul ? ST_BUSY : ST_HOLD;
                    load_alu = ~is_mul;
                end else if (bus.out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // single-cycle datapath; ADC uses the carry held in the result register
    always_comb begin
        res   = '0;
        opb   = bus.b;
        nb    = '0 - bus.b;
        shl   = {1'b0, bus.a} << bus.b;
        shr   = {bus.a, 1'b0} >> bus.b;
        c     = 1'b0;
        ill   = 1'b0;
        arith = 1'b0;
        unique case (1'b1)
            (bus.op == OP_SUM): begin
                {c, res} = {1'b0, bus.a} + {1'b0, bus.b};
                arith    = 1'b1;
            end
            (bus.op == OP_ADC): begin
                {c, res} = {1'b0, bus.a} + {1'b0, bus.b} +
                           {{WIDTH{1'b0}}, flags_q[FLAG_CARRY]};
                arith    = 1'b1;
            end
            (bus.op == OP_SUB): begin
                res   = bus.a + nb;
                c     = (bus.a < bus.b);
                opb   = nb;
                arith = 1'b1;
            end
            (bus.op == OP_AND): res = bus.a & bus.b;
            (bus.op == OP_OR):  res = bus.a | bus.b;
            (bus.op == OP_NOT): res = ~bus.a;
            (bus.op == OP_LSL): begin
                res = shl[WIDTH-1:0];
                c   = shl[WIDTH];
            end
            (bus.op == OP_LSR): begin
                res = shr[WIDTH:1];
                c   = shr[0];
            end
            default: ill = 1'b1;
        endcase
        v = arith & (bus.a[WIDTH-1] == opb[WIDTH-1]) &
            (res[WIDTH-1] != bus.a[WIDTH-1]);
        alu_flags = pack_flags(ill, ~^res, res == '0, v,
                               res[WIDTH-1], c);
    end

    always_comb begin
        mul_lo    = mul_prod[WIDTH-1:0];
        mul_hi    = mul_prod[2*WIDTH-1:WIDTH];
        mul_flags = pack_flags(1'b0, ~^mul_lo, mul_lo == '0, 1'b0,
                               mul_lo[WIDTH-1], |mul_hi);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
        end else if (load_mul) begin
            out_q   <= mul_lo;
            hi_q    <= mul_hi;
            flags_q <= mul_flags;
        end else if (load_alu) begin
            out_q   <= res;
            hi_q    <= '0;
            flags_q <= alu_flags;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, multi-cycle
// sequences, and a random stream against a plain-arithmetic reference model.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] out;
        logic [7:0] flags;
    } vec_t;

    vec_t tbl[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic mcarry  = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string name, input logic [3:0] op,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] o, input logic [7:0] f);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.out = o; v.flags = f;
        tbl.push_back(v);
    endtask

    // returns {out_hi, out, flags}
    function automatic logic [23:0] model(input logic [3:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic cin);
        int ia, ib, sa, r, s, ci;
        logic signed [7:0] t;
        logic [7:0] o, hi;
        logic c, v, ill;
        ia = a; ib = b; sa = $signed(a);
        ci = (op == 4'd7) ? int'(cin) : 0;
        o = 8'h00; hi = 8'h00; c = 1'b0; v = 1'b0; ill = 1'b0;
        case (op)
            4'd0, 4'd7: begin
                s = ia + ib + ci;
                o = s[7:0];
                c = (s > 255);
                r = sa + int'($signed(b)) + ci;
                v = (r > 127) || (r < -128);
            end
            4'd1: begin
                s = ia - ib;
                o = s[7:0];
                c = (ia < ib);
                s = (256 - ib) % 256;
                t = s[7:0];
                r = sa + int'(t);
                v = (r > 127) || (r < -128);
            end
            4'd2: o = a & b;
            4'd3: o = a | b;
            4'd4: o = ~a;
            4'd5: begin
                if (ib == 0) o = a;
                else if (ib <= 8) begin
                    s = (ia << ib) & 255;
                    o = s[7:0];
                    c = ((ia >> (8 - ib)) & 1) != 0;
                end
            end
            4'd6: begin
                if (ib == 0) o = a;
                else if (ib <= 8) begin
                    s = ia >> ib;
                    o = s[7:0];
                    c = ((ia >> (ib - 1)) & 1) != 0;
                end
            end
            4'd8: begin
                s = ia * ib;
                o = s[7:0];
                hi = s[15:8];
                c = (hi != 0);
            end
            default: ill = 1'b1;
        endcase
        return {hi, o, 2'b00, ill, ~^o, (o == 8'h00), v, o[7], c};
    endfunction

    initial begin
        logic [23:0] exp;
        logic [3:0]  rop;
        int          cnt;
        int          delivered;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.op = 4'd0; bus.a = 8'h00; bus.b = 8'h00;
        bus.out_ready = 1'b0;

        tick(); tick();
        check("reset_out", 32'(bus.out), 32'h00);
        check("reset_hi", 32'(bus.out_hi), 32'h00);
        check("reset_flags", 32'(bus.flags), 32'h00);
        check("reset_out_valid", 32'(bus.out_valid), 32'h0);
        check("reset_in_ready", 32'(bus.in_ready), 32'h1);
        rst = 1'b0;
        tick();

        add_vec("sum_ff_01",  OP_SUM, 8'hFF, 8'h01, 8'h00, 8'h19);
        add_vec("sum_7f_01",  OP_SUM, 8'h7F, 8'h01, 8'h80, 8'h06);
        add_vec("sub_80_01",  OP_SUB, 8'h80, 8'h01, 8'h7F, 8'h04);
        add_vec("sub_01_02",  OP_SUB, 8'h01, 8'h02, 8'hFF, 8'h13);
        add_vec("and",        OP_AND, 8'hF0, 8'h3C, 8'h30, 8'h10);
        add_vec("or",         OP_OR,  8'h0F, 8'hF0, 8'hFF, 8'h12);
        add_vec("not",        OP_NOT, 8'h55, 8'h00, 8'hAA, 8'h12);
        add_vec("lsl_81_1",   OP_LSL, 8'h81, 8'h01, 8'h02, 8'h01);
        add_vec("lsl_81_8",   OP_LSL, 8'h81, 8'h08, 8'h00, 8'h19);
        add_vec("lsl_81_9",   OP_LSL, 8'h81, 8'h09, 8'h00, 8'h18);
        add_vec("lsr_81_0",   OP_LSR, 8'h81, 8'h00, 8'h81, 8'h12);
        add_vec("lsr_81_8",   OP_LSR, 8'h81, 8'h08, 8'h00, 8'h19);
        add_vec("lsr_81_9",   OP_LSR, 8'h81, 8'h09, 8'h00, 8'h18);
        add_vec("illegal_f",  4'hF,   8'h12, 8'h34, 8'h00, 8'h38);

        foreach (tbl[i]) begin
            bus.in_valid = 1'b1;
            bus.op = tbl[i].op; bus.a = tbl[i].a; bus.b = tbl[i].b;
            tick();
            bus.in_valid = 1'b0;
            check({tbl[i].name, "_result"},
                  {bus.out_valid, bus.in_ready, bus.out_hi, bus.out, bus.flags},
                  {2'b10, 8'h00, tbl[i].out, tbl[i].flags});
            mcarry = tbl[i].flags[0];
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            check({tbl[i].name, "_drain"}, 32'(bus.out_valid), 32'h0);
        end

        // ADC picks up the carry of the result consumed in the same cycle
        bus.in_valid = 1'b1; bus.op = OP_SUM; bus.a = 8'hFF; bus.b = 8'h01;
        tick();
        bus.out_ready = 1'b1; bus.op = OP_ADC; bus.a = 8'h01; bus.b = 8'h01;
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        check("adc_chain", {bus.out_valid, bus.out, bus.flags},
              {1'b1, 8'h03, 8'h10});
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        mcarry = 1'b0;

        // MUL latency, with operands scrambled after accept
        bus.in_valid = 1'b1; bus.op = OP_MUL; bus.a = 8'h10; bus.b = 8'h20;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            check($sformatf("mul_busy_%0d", i),
                  {bus.in_ready, bus.out_valid}, 2'b00);
            bus.a = 8'($urandom); bus.b = 8'($urandom);
            bus.op = 4'($urandom);
            tick();
        end
        check("mul_10_20", {bus.out_valid, bus.out_hi, bus.out, bus.flags},
              {1'b1, 8'h02, 8'h00, 8'h19});
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;

        // reset during BUSY cycle 4 aborts the multiply
        bus.in_valid = 1'b1; bus.op = OP_MUL; bus.a = 8'hFF; bus.b = 8'hFF;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("abort_outputs",
              {bus.out_valid, bus.in_ready, bus.out_hi, bus.out, bus.flags},
              {2'b01, 8'h00, 8'h00, 8'h00});
        tick();
        rst = 1'b0;
        mcarry = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3 * W; i++) begin
            tick();
            if (bus.out_valid) cnt++;
        end
        check("abort_no_result", 32'(cnt), 32'h0);

        bus.in_valid = 1'b1; bus.op = OP_ADC; bus.a = 8'h01; bus.b = 8'h01;
        tick();
        bus.in_valid = 1'b0;
        check("adc_after_abort", {bus.out_valid, bus.out, bus.flags},
              {1'b1, 8'h02, 8'h00});
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;

        // stalled result holds while the producer keeps offering new ops
        bus.in_valid = 1'b1; bus.op = 4'hF; bus.a = 8'h5A; bus.b = 8'hA5;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.op = 4'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
            #1;
            check($sformatf("stall_%0d", i),
                  {bus.in_ready, bus.out_valid, bus.out_hi, bus.out, bus.flags},
                  {2'b01, 8'h00, 8'h00, 8'h38});
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        mcarry = 1'b0;

        // random single-cycle stream at full throughput
        delivered = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cnt = $urandom_range(0, 14);
            rop = (cnt >= 8) ? 4'(cnt + 1) : 4'(cnt);
            bus.op = rop;
            bus.a = 8'($urandom);
            bus.b = (rop == OP_LSL || rop == OP_LSR) ?
                    8'($urandom_range(0, 11)) : 8'($urandom);
            exp = model(rop, bus.a, bus.b, mcarry);
            bus.in_valid = 1'b1;
            tick();
            if (bus.out_valid) delivered++;
            check($sformatf("stream_%0d_op%0d", i, rop),
                  {bus.out_valid, bus.out_hi, bus.out, bus.flags},
                  {1'b1, exp});
            mcarry = exp[0];
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        check("stream_throughput", 32'(delivered), 32'd200);

        // random multiplies with bounded wait
        for (int i = 0; i < 12; i++) begin
            bus.op = OP_MUL; bus.a = 8'($urandom); bus.b = 8'($urandom);
            exp = model(OP_MUL, bus.a, bus.b, mcarry);
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            cnt = 0;
            while (!bus.out_valid && cnt < 20) begin
                bus.a = 8'($urandom); bus.b = 8'($urandom);
                tick();
                cnt++;
            end
            check($sformatf("mul_rand_%0d_latency", i), 32'(cnt), 32'(W));
            check($sformatf("mul_rand_%0d", i),
                  {bus.out_valid, bus.out_hi, bus.out, bus.flags},
                  {1'b1, exp});
            mcarry = exp[0];
            bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
